// File: rtl/demux_scan_sched.sv
// Round-robin select sequencer for a 1-to-16 demux: scans enabled channels,
// holds each for dwell+1 cycles, and pulses wrap on the first cycle of every new lap.
module demux_scan_sched #(
  parameter int N_CH    = 16,
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [N_CH-1:0]    chan_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               wrap,
  output logic               busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DWELL = 1'b1;

  logic [0:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   base;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   nxt;
  logic               found;

  // Search upward from base, modulo N_CH. The base is 0 when starting a scan,
  // and sel+1 when advancing. A single enabled channel is found again at i=N_CH-1.
  always_comb begin
    base  = (state == ST_IDLE) ? '0 : sel + 1'b1;
    idx   = '0;
    nxt   = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = base + SEL_W'(i);
      if (!found && chan_en[idx]) begin
        found = 1'b1;
        nxt   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else if (stop) begin
      state <= ST_IDLE;
      sel   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wrap <= 1'b0;
          if (start && found) begin
            state <= ST_DWELL;
            sel   <= nxt;
            cnt   <= dwell;
          end
        end
        ST_DWELL: begin
          if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            wrap <= 1'b0;
          end else if (found) begin
            // A lap restarts whenever the search wrapped past the top index.
            sel  <= nxt;
            cnt  <= dwell;
            wrap <= (nxt <= sel);
          end else begin
            state <= ST_IDLE;
            sel   <= '0;
            wrap  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          sel   <= '0;
          cnt   <= '0;
          wrap  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state == ST_DWELL);
  assign sel_valid = (state == ST_DWELL);

endmodule
